sysarr_out_drain: RTL and testbench

Drain stage directly downstream of the systolic array output FIFO. It counts the same `shift` strobes that load the output FIFO. Each time a full row of N results has been assembled, it captures the packed row into a 2-entry queue. It then issues one memory write per row over a valid/ready port, with an address computed from a tile base address. It tracks rows per tile, reports tile completion, and flags rows lost to back-pressure.

---
 rtl/sysarr_out_drain.sv | 125 ++++++++++++
 tb/tb_sysarr_out_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarr_out_drain.sv
// Drain stage behind the systolic array output FIFO: assembles rows from shift
// strobes, queues them (2 deep) and issues one addressed memory write per row.
module sysarr_out_drain #(
    parameter int DW          = 16,
    parameter int N           = 4,
    parameter int ROWS        = 4,
    parameter int AW          = 16,
    parameter int ADDR_STRIDE = 1
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic            shift,
    input  logic [DW*N-1:0] fifo_row,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [AW-1:0]   wr_addr,
    output logic [DW*N-1:0] wr_data,
    output logic            busy,
    output logic            tile_done,
    output logic            overflow
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

    state_t          state;
    logic [CW-1:0]   elem_cnt;
    logic [RW-1:0]   rows_captured;
    logic            cap_pending;
    logic [AW-1:0]   base_addr_q;

    logic [DW*N-1:0] q_data [2];
    logic [AW-1:0]   q_addr [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      q_cnt;

    logic            pop;
    logic            push_ok;
    logic            q_full;
    logic [AW-1:0]   row_addr;

    assign q_full   = (q_cnt == 2'd2);
    assign pop      = wr_valid && wr_ready;
    // A full queue still accepts a row when the head leaves in the same cycle.
    assign push_ok  = cap_pending && (!q_full || pop);
    // Index counts every capture, dropped ones included, so addresses stay aligned.
    assign row_addr = base_addr_q + AW'(rows_captured) * AW'(ADDR_STRIDE);

    assign wr_valid = (q_cnt != 2'd0);
    assign wr_addr  = q_addr[rd_ptr];
    assign wr_data  = q_data[rd_ptr];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            elem_cnt      <= '0;
            rows_captured <= '0;
            cap_pending   <= 1'b0;
            base_addr_q   <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            q_cnt         <= 2'd0;
            tile_done     <= 1'b0;
            overflow      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
        end else begin
            tile_done <= 1'b0;
            if (start) begin
                state         <= COLLECT;
                elem_cnt      <= '0;
                rows_captured <= '0;
                cap_pending   <= 1'b0;
                base_addr_q   <= base_addr;
                rd_ptr        <= 1'b0;
                wr_ptr        <= 1'b0;
                q_cnt         <= 2'd0;
                overflow      <= 1'b0;
            end else begin
                case (state)
                    COLLECT: if (rows_captured == RW'(ROWS)) state <= FLUSH;
                    FLUSH: begin
                        if (q_cnt == 2'd0) begin
                            state     <= IDLE;
                            tile_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                // fifo_row still holds the completed row here, even if a shift lands now.
                cap_pending <= 1'b0;
                if (state == COLLECT && shift) begin
                    if (elem_cnt == CW'(N - 1)) begin
                        elem_cnt    <= '0;
                        cap_pending <= (rows_captured < RW'(ROWS));
                    end else begin
                        elem_cnt <= elem_cnt + CW'(1);
                    end
                end

                if (cap_pending) begin
                    rows_captured <= rows_captured + RW'(1);
                    if (push_ok) begin
                        q_data[wr_ptr] <= fifo_row;
                        q_addr[wr_ptr] <= row_addr;
                        wr_ptr         <= ~wr_ptr;
                    end else begin
                        overflow <= 1'b1;
                    end
                end

                if (pop) rd_ptr <= ~rd_ptr;
                q_cnt <= q_cnt + 2'(push_ok) - 2'(pop);
            end
        end
    end
endmodule

// File: tb/tb_sysarr_out_drain.sv
// Bench for sysarr_out_drain: directed steps plus random traffic, checked every
// cycle against a transaction-level model built from shift history and a queue.
module tb_sysarr_out_drain;
    localparam int DW = 16, N = 4, ROWS = 4, AW = 8, STRIDE = 4;

    logic            clk = 1'b0;
    logic            nRST, start, shift, wr_ready;
    logic [AW-1:0]   base_addr;
    logic [DW-1:0]   din;
    logic [DW*N-1:0] fifo_row = '0;
    logic            wr_valid, busy, tile_done, overflow;
    logic [AW-1:0]   wr_addr;
    logic [DW*N-1:0] wr_data;

    int    checks = 0, errors = 0;
    string phase = "init";

    always #5 clk = ~clk;

    sysarr_out_drain #(.DW(DW), .N(N), .ROWS(ROWS), .AW(AW), .ADDR_STRIDE(STRIDE)) dut (
        .clk(clk), .nRST(nRST), .start(start), .base_addr(base_addr), .shift(shift),
        .fifo_row(fifo_row), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .tile_done(tile_done), .overflow(overflow)
    );

    // Upstream output FIFO: a plain shift register, first-shifted element ends on top.
    always @(posedge clk) if (shift) fifo_row <= {fifo_row[DW*(N-1)-1:0], din};

    // Observed traffic on the write port, for directed end-of-test checks.
    logic [AW-1:0] acc_addr[$];
    int            done_cnt = 0;
    always @(posedge clk) begin
        if (nRST && wr_valid && wr_ready) acc_addr.push_back(wr_addr);
        if (tile_done) done_cnt++;
    end

    // Reference model
    typedef struct packed {logic [AW-1:0] a; logic [DW*N-1:0] d;} wr_t;
    wr_t             mq[$];
    logic [DW-1:0]   hist[$];
    int              m_st, m_cnt, m_rows;   // m_st: 0 idle, 1 collecting, 2 flushing
    bit              m_pend, m_ovf, m_done;
    logic [DW*N-1:0] m_row;
    logic [AW-1:0]   m_base;

    function automatic logic [DW*N-1:0] hist_row();
        logic [DW*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[DW*(N-i)-1 -: DW] = hist[i];
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_st = 0; m_cnt = 0; m_rows = 0;
        m_pend = 0; m_ovf = 0; m_done = 0; m_base = '0;
    endtask

    task automatic model_edge();
        int old_st   = m_st;
        int old_rows = m_rows;
        int old_sz   = mq.size();
        bit old_pend = m_pend;
        bit pop      = (old_sz > 0) && wr_ready;
        if (shift) begin
            hist.push_back(din);
            void'(hist.pop_front());
        end
        m_done = 0;
        if (start) begin
            mq.delete();
            m_cnt = 0; m_rows = 0; m_pend = 0; m_ovf = 0;
            m_base = base_addr; m_st = 1;
            return;
        end
        if (old_st == 2 && old_sz == 0) begin
            m_st = 0; m_done = 1;
        end else if (old_st == 1 && old_rows == ROWS) begin
            m_st = 2;
        end
        if (pop) void'(mq.pop_front());
        m_pend = 0;
        if (old_pend) begin
            if (mq.size() < 2) mq.push_back('{a: m_base + AW'(old_rows * STRIDE), d: m_row});
            else m_ovf = 1;
            m_rows++;
        end
        if (old_st == 1 && shift) begin
            if (m_cnt == N - 1) begin
                m_cnt = 0;
                if (old_rows < ROWS) begin
                    m_pend = 1;
                    m_row  = hist_row();
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk({phase, ".wr_valid"}, 64'(wr_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk({phase, ".wr_addr"}, 64'(wr_addr), 64'(mq[0].a));
            chk({phase, ".wr_data"}, 64'(wr_data), 64'(mq[0].d));
        end
        chk({phase, ".busy"}, 64'(busy), 64'(m_st != 0));
        chk({phase, ".tile_done"}, 64'(tile_done), 64'(m_done));
        chk({phase, ".overflow"}, 64'(overflow), 64'(m_ovf));
    endtask

    task automatic cyc(input bit st, input bit sh, input logic [DW-1:0] d, input bit rdy);
        @(negedge clk);
        start = st; shift = sh; din = d; wr_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, rdy);
    endtask

    task automatic shifts(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, DW'($urandom), rdy);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".wr_valid0"}, 64'(wr_valid), 64'd0);
        chk({tag, ".wr_addr0"}, 64'(wr_addr), 64'd0);
        chk({tag, ".wr_data0"}, 64'(wr_data), 64'd0);
        chk({tag, ".busy0"}, 64'(busy), 64'd0);
        chk({tag, ".tile_done0"}, 64'(tile_done), 64'd0);
        chk({tag, ".overflow0"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int n0, d0;
        nRST = 1'b0; start = 1'b0; shift = 1'b0; din = '0; wr_ready = 1'b0; base_addr = '0;
        repeat (N) hist.push_back('0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        nRST = 1'b1;

        // Single row: valid appears two edges after the 4th shift
        phase = "single"; base_addr = 8'h40;
        cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b1, 16'h0011, 1'b1);
        cyc(1'b0, 1'b1, 16'h0022, 1'b1);
        cyc(1'b0, 1'b1, 16'h0033, 1'b1);
        cyc(1'b0, 1'b1, 16'h0044, 1'b1);
        chk("single.not_yet", 64'(wr_valid), 64'd0);
        idle(1, 1'b1);
        chk("single.valid", 64'(wr_valid), 64'd1);
        chk("single.addr", 64'(wr_addr), 64'h40);
        chk("single.data", 64'(wr_data), 64'h0011_0022_0033_0044);
        idle(2, 1'b1);

        // Full tile, back-to-back shifts
        phase = "tile"; base_addr = 8'h80;
        n0 = acc_addr.size(); d0 = done_cnt;
        cyc(1'b1, 1'b0, '0, 1'b1);
        shifts(4 * ROWS, 1'b1);
        idle(8, 1'b1);
        chk("tile.writes", 64'(acc_addr.size() - n0), 64'(ROWS));
        for (int i = 0; i < ROWS; i++)
            if (acc_addr.size() > n0 + i) chk("tile.addr", 64'(acc_addr[n0+i]), 64'(8'h80 + 4 * i));
        chk("tile.done_once", 64'(done_cnt - d0), 64'd1);
        chk("tile.busy_low", 64'(busy), 64'd0);

        // Back-pressure: two rows fit, the rest are dropped
        phase = "bp"; base_addr = 8'h20;
        n0 = acc_addr.size(); d0 = done_cnt;
        cyc(1'b1, 1'b0, '0, 1'b0);
        shifts(4 * ROWS, 1'b0);
        idle(4, 1'b0);
        idle(8, 1'b1);
        chk("bp.writes", 64'(acc_addr.size() - n0), 64'd2);
        if (acc_addr.size() >= n0 + 2) begin
            chk("bp.addr0", 64'(acc_addr[n0]), 64'h20);
            chk("bp.addr1", 64'(acc_addr[n0+1]), 64'h24);
        end
        chk("bp.overflow", 64'(overflow), 64'd1);
        chk("bp.done", 64'(done_cnt - d0), 64'd1);

        // Push and pop coincide with the queue full
        phase = "pushpop"; base_addr = 8'h50;
        n0 = acc_addr.size();
        cyc(1'b1, 1'b0, '0, 1'b0);
        shifts(12, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        chk("pushpop.no_drop", 64'(overflow), 64'd0);
        shifts(4, 1'b1);
        idle(8, 1'b1);
        chk("pushpop.writes", 64'(acc_addr.size() - n0), 64'(ROWS));
        for (int i = 0; i < ROWS; i++)
            if (acc_addr.size() > n0 + i) chk("pushpop.order", 64'(acc_addr[n0+i]), 64'(8'h50 + 4 * i));
        chk("pushpop.overflow", 64'(overflow), 64'd0);

        // Mid-row restart, then address wrap past 0xFF
        phase = "wrap"; base_addr = 8'hFE;
        n0 = acc_addr.size();
        cyc(1'b1, 1'b0, '0, 1'b1);
        shifts(2, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 16'h00A1, 1'b0);
        cyc(1'b0, 1'b1, 16'h00A2, 1'b0);
        cyc(1'b0, 1'b1, 16'h00A3, 1'b0);
        cyc(1'b0, 1'b1, 16'h00A4, 1'b0);
        idle(1, 1'b0);
        chk("wrap.addr0", 64'(wr_addr), 64'hFE);
        chk("wrap.data0", 64'(wr_data), 64'h00A1_00A2_00A3_00A4);
        shifts(12, 1'b1);
        idle(8, 1'b1);
        if (acc_addr.size() >= n0 + 2) begin
            chk("wrap.first", 64'(acc_addr[n0]), 64'hFE);
            chk("wrap.second", 64'(acc_addr[n0+1]), 64'h02);
        end else begin
            chk("wrap.writes", 64'(acc_addr.size() - n0), 64'(ROWS));
        end

        // Random traffic with occasional restarts
        for (int t = 0; t < 6; t++) begin
            phase = "rand"; base_addr = AW'($urandom);
            cyc(1'b1, 1'b0, '0, 1'b1);
            for (int c = 0; c < 120; c++)
                cyc($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, DW'($urandom),
                    $urandom_range(0, 3) != 0);
            idle(10, 1'b1);
        end

        // Reset mid-tile with a write pending
        phase = "rstmid"; base_addr = 8'h30;
        cyc(1'b1, 1'b0, '0, 1'b0);
        shifts(4, 1'b0);
        idle(1, 1'b0);
        chk("rstmid.pending", 64'(wr_valid), 64'd1);
        @(negedge clk);
        nRST = 1'b0;
        #1;
        chk_zero_outputs("rstmid");
        model_clear();
        @(negedge clk);
        nRST = 1'b1;
        n0 = acc_addr.size();
        shifts(8, 1'b1);
        idle(2, 1'b1);
        chk("rstmid.no_writes", 64'(acc_addr.size() - n0), 64'd0);
        chk("rstmid.idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
